// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-unit definitions: funct3 branch encodings and BHT counter type/constants.
package branch_resolve_unit_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_CTR_RESET = 2'b01;
    localparam bht_ctr_t BHT_CTR_MAX   = 2'b11;

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// It has a registered read port and a saturating update port; a read returns the pre-update value.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output bht_ctr_t             rd_ctr,
    input  logic                 wr_en,
    input  logic [BHT_IDX_W-1:0] wr_idx,
    input  logic                 wr_taken
);

    bht_ctr_t ctr_q [BHT_ENTRIES];
    bht_ctr_t ctr_d [BHT_ENTRIES];
    bht_ctr_t rd_ctr_q, rd_ctr_d;
    bht_ctr_t cur;

    always_comb begin
        ctr_d    = ctr_q;
        cur      = ctr_q[wr_idx];
        rd_ctr_d = rd_en ? ctr_q[rd_idx] : '0;
        if (wr_en) begin
            if (wr_taken)
                ctr_d[wr_idx] = (cur == BHT_CTR_MAX) ? cur : bht_ctr_t'(cur + 2'd1);
            else
                ctr_d[wr_idx] = (cur == 2'b00) ? cur : bht_ctr_t'(cur - 2'd1);
        end
    end

    // Reset wins over any pending write, so a write presented in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= BHT_CTR_RESET;
            rd_ctr_q <= '0;
        end else begin
            ctr_q    <= ctr_d;
            rd_ctr_q <= rd_ctr_d;
        end
    end

    assign rd_ctr = rd_ctr_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch predictor and resolver: BHT lookup for fetch, compare/mispredict/train in execute.
// Optional BRU_PERF_CNT_EN adds 32-bit branch and mispredict performance counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_req,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_is_branch,
    input  logic            res_is_jump,
    input  logic [XLEN-1:0] res_pc,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic            res_pred_taken,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    logic     pred_valid_q, pred_valid_d;
    logic     res_taken_q, res_taken_d;
    logic     res_mispredict_q, res_mispredict_d;
    logic     res_illegal_q, res_illegal_d;
    logic     bht_wr_en;
    bht_ctr_t rd_ctr;
    logic     eq, lt_s, lt_u;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:BHT_IDX_W+2], res_pc[1:0], rd_ctr[0]};

    assign eq   = (res_rs1 == res_rs2);
    assign lt_s = ($signed(res_rs1) < $signed(res_rs2));
    assign lt_u = (res_rs1 < res_rs2);

    always_comb begin
        pred_valid_d     = pred_req;
        res_taken_d      = 1'b0;
        res_mispredict_d = 1'b0;
        res_illegal_d    = 1'b0;
        bht_wr_en        = 1'b0;
        if (res_valid) begin
            // Jumps win when both decode flags are set and never train the BHT.
            if (res_is_jump) begin
                res_taken_d      = 1'b1;
                res_mispredict_d = !res_pred_taken;
            end else if (res_is_branch) begin
                unique case (res_funct3)
                    BEQ:     res_taken_d = eq;
                    BNE:     res_taken_d = !eq;
                    BLT:     res_taken_d = lt_s;
                    BGE:     res_taken_d = !lt_s;
                    BLTU:    res_taken_d = lt_u;
                    BGEU:    res_taken_d = !lt_u;
                    default: res_illegal_d = 1'b1;
                endcase
                res_mispredict_d = (res_taken_d != res_pred_taken);
                bht_wr_en        = !res_illegal_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q     <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            res_illegal_q    <= 1'b0;
        end else begin
            pred_valid_q     <= pred_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            res_illegal_q    <= res_illegal_d;
        end
    end

    bht_2bit #(
        .BHT_ENTRIES(BHT_ENTRIES),
        .BHT_IDX_W  (BHT_IDX_W)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (pred_req),
        .rd_idx  (pred_pc[BHT_IDX_W+1:2]),
        .rd_ctr  (rd_ctr),
        .wr_en   (bht_wr_en),
        .wr_idx  (res_pc[BHT_IDX_W+1:2]),
        .wr_taken(res_taken_d)
    );

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = rd_ctr[1];
    assign res_taken      = res_taken_q;
    assign res_mispredict = res_mispredict_q;
    assign res_illegal    = res_illegal_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (res_valid && (res_is_branch || res_is_jump)) perf_branches_d = perf_branches_q + 32'd1;
        if (res_mispredict_d) perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a spec-level model pushes expected outputs per cycle,
// and a negedge monitor pops and compares them against the DUT.
module tb_branch_resolve_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            pred_req;
    logic [XLEN-1:0] pred_pc;
    logic            pred_valid, pred_taken;
    logic            res_valid, res_is_branch, res_is_jump;
    logic [XLEN-1:0] res_pc, res_rs1, res_rs2;
    logic [2:0]      res_funct3;
    logic            res_pred_taken;
    logic            res_taken, res_mispredict, res_illegal;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     perf_branches, perf_mispredicts;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_req      (pred_req),
        .pred_pc       (pred_pc),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .res_valid     (res_valid),
        .res_is_branch (res_is_branch),
        .res_is_jump   (res_is_jump),
        .res_pc        (res_pc),
        .res_funct3    (res_funct3),
        .res_rs1       (res_rs1),
        .res_rs2       (res_rs2),
        .res_pred_taken(res_pred_taken),
        .res_taken     (res_taken),
        .res_mispredict(res_mispredict),
        .res_illegal   (res_illegal)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches   (perf_branches),
        .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pv, pt, rt, rm, ri;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          bht_m [ENTRIES];
    logic [31:0] n_br, n_mis;

    // Spec-level model: counters are plain integers 0..3, prediction is "counter >= 2".
    task automatic tick();
        exp_t e;
        int   pi, ri;
        logic tk, ill;
        pi = int'((pred_pc >> 2) % ENTRIES);
        ri = int'((res_pc >> 2) % ENTRIES);
        e  = '0;
        if (rst) begin
            foreach (bht_m[i]) bht_m[i] = 1;
            n_br  = 0;
            n_mis = 0;
        end else begin
            e.pv = pred_req;
            e.pt = pred_req && (bht_m[pi] >= 2);
            if (res_valid && (res_is_jump || res_is_branch)) begin
                ill = 1'b0;
                tk  = 1'b0;
                if (res_is_jump) tk = 1'b1;
                else case (res_funct3)
                    3'b000: tk = (res_rs1 == res_rs2);
                    3'b001: tk = (res_rs1 != res_rs2);
                    3'b100: tk = ($signed(res_rs1) <  $signed(res_rs2));
                    3'b101: tk = ($signed(res_rs1) >= $signed(res_rs2));
                    3'b110: tk = (res_rs1 <  res_rs2);
                    3'b111: tk = (res_rs1 >= res_rs2);
                    default: ill = 1'b1;
                endcase
                e.rt = tk;
                e.rm = (tk != res_pred_taken);
                e.ri = ill;
                n_br++;
                if (e.rm) n_mis++;
                if (!res_is_jump && !ill)
                    bht_m[ri] = tk ? ((bht_m[ri] == 3) ? 3 : bht_m[ri] + 1)
                                   : ((bht_m[ri] == 0) ? 0 : bht_m[ri] - 1);
            end
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_req = 0; res_valid = 0; res_is_branch = 0; res_is_jump = 0;
        pred_pc = 0; res_pc = 0; res_funct3 = 0; res_rs1 = 0; res_rs2 = 0; res_pred_taken = 0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        idle(); pred_req = 1; pred_pc = pc; tick();
    endtask

    task automatic resolve(input logic br, input logic jp, input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic ppt);
        idle(); res_valid = 1; res_is_branch = br; res_is_jump = jp; res_pc = pc;
        res_funct3 = f3; res_rs1 = a; res_rs2 = b; res_pred_taken = ppt; tick();
    endtask

    // Monitor: the DUT presents its registered outputs every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e, g;
            e = expq.pop_front();
            g = '{pred_valid, pred_taken, res_taken, res_mispredict, res_illegal};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got pv/pt/rt/rm/ri=%b required %b", $time, g, e);
            end
        end
    end

    initial begin
        idle();
        rst = 1; tick(); tick();
        rst = 0;
        // Lookup after reset: weakly not-taken.
        lookup(32'h100);
        // Train taken three times, then look up.
        repeat (3) resolve(1, 0, 32'h100, 3'b000, 32'd5, 32'd5, 1'b0);
        lookup(32'h100);
        // Signed vs unsigned compares.
        resolve(1, 0, 32'h200, 3'b111, 32'h1, 32'hFFFF_FFFF, 1'b0);
        resolve(1, 0, 32'h200, 3'b101, 32'h1, 32'hFFFF_FFFF, 1'b0);
        resolve(1, 0, 32'h204, 3'b100, 32'h8000_0000, 32'h0, 1'b0);
        resolve(1, 0, 32'h208, 3'b110, 32'h0, 32'h8000_0000, 1'b1);
        resolve(1, 0, 32'h20C, 3'b001, 32'h7, 32'h7, 1'b1);
        // Same-cycle lookup and update of one index: old value is returned.
        idle(); pred_req = 1; pred_pc = 32'h300; res_valid = 1; res_is_branch = 1;
        res_pc = 32'h300; res_funct3 = 3'b000; res_rs1 = 9; res_rs2 = 9; tick();
        lookup(32'h300);
        // Jump never trains; illegal funct3 flags and does not train.
        resolve(0, 1, 32'h400, 3'b000, 32'h1, 32'h2, 1'b0);
        resolve(1, 1, 32'h400, 3'b000, 32'h1, 32'h2, 1'b1);
        lookup(32'h400);
        resolve(1, 0, 32'h500, 3'b010, 32'h3, 32'h3, 1'b1);
        resolve(1, 0, 32'h500, 3'b011, 32'h3, 32'h3, 1'b0);
        lookup(32'h500);
        resolve(0, 0, 32'h500, 3'b000, 32'h3, 32'h3, 1'b1);
        // Reset with a resolve in flight: nothing trains, outputs clear, counters back to weakly not-taken.
        resolve(1, 0, 32'h100, 3'b000, 32'd1, 32'd1, 1'b0);
        rst = 1; res_valid = 1; res_is_branch = 1; pred_req = 1; pred_pc = 32'h100; tick();
        rst = 0;
        lookup(32'h100);
        // Four branches, two mispredicts.
        resolve(1, 0, 32'h600, 3'b000, 32'd1, 32'd1, 1'b1);
        resolve(1, 0, 32'h600, 3'b000, 32'd1, 32'd2, 1'b1);
        resolve(0, 1, 32'h604, 3'b000, 32'd1, 32'd2, 1'b0);
        resolve(1, 0, 32'h608, 3'b110, 32'd1, 32'd2, 1'b1);
        idle(); tick();
`ifdef BRU_PERF_CNT_EN
        checks++;
        if (perf_branches !== 32'd4 || perf_mispredicts !== 32'd2) begin
            errors++;
            $display("FAIL perf_4_2 got %0d/%0d required 4/2", perf_branches, perf_mispredicts);
        end
`endif
        // Randomized traffic over a few PCs so indices collide and same-cycle conflicts occur.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            rst            = ($urandom_range(0, 60) == 0);
            pred_req       = $urandom_range(0, 1);
            pred_pc        = {$urandom_range(0, 7), 2'($urandom)} << 2 | 32'($urandom_range(0, 3));
            pred_pc        = (pred_pc & 32'h1F) | (32'($urandom_range(0, 1)) << 8);
            res_valid      = ($urandom_range(0, 3) != 0);
            res_is_branch  = ($urandom_range(0, 4) != 0);
            res_is_jump    = ($urandom_range(0, 7) == 0);
            res_pc         = (($urandom_range(0, 1) == 0) ? pred_pc : 32'($urandom_range(0, 7) << 2));
            res_funct3     = 3'($urandom);
            a              = $urandom;
            res_rs1        = a;
            res_rs2        = ($urandom_range(0, 2) == 0) ? a : $urandom;
            res_pred_taken = $urandom_range(0, 1);
            tick();
        end
        rst = 0;
        idle(); tick();
`ifdef BRU_PERF_CNT_EN
        checks++;
        if (perf_branches !== n_br || perf_mispredicts !== n_mis) begin
            errors++;
            $display("FAIL perf_final got %0d/%0d required %0d/%0d", perf_branches, perf_mispredicts, n_br, n_mis);
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
